mix_scheduler: RTL and testbench

MIX_SCHEDULER -- requirements
Module: mix_scheduler

---
 rtl/mix_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_mix_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_scheduler.sv
// mix_scheduler: frame-based audio mixer front end.
// On each sample tick it walks the enabled channels in ascending index order.
// For each channel it fetches one sample through a req/ack handshake and
// accumulates sample * volume. It then emits (acc >>> 3) saturated to
// WIDTH bits. A volume of 8 is unity gain.

module mix_scheduler #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int VOL_W    = 4
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic                          sample_tick_in,
   output logic                          ch_req_out,
   output logic [$clog2(CHANNELS)-1:0]   ch_sel_out,
   input  logic                          ch_ack_in,
   input  logic signed [WIDTH-1:0]       ch_data_in,
   input  logic [CHANNELS-1:0]           mute_in,
   input  logic [CHANNELS*VOL_W-1:0]     volume_in,
   input  logic                          solo_enable_in,
   input  logic [4:0]                    solo_in,
   output logic signed [WIDTH-1:0]       mix_out,
   output logic                          mix_valid_out,
   output logic                          busy_out,
   output logic                          overrun_out
);

   localparam int SEL_W  = $clog2(CHANNELS);
   // Widest single product: signed WIDTH x unsigned VOL_W needs WIDTH+VOL_W+1
   localparam int PROD_W = WIDTH + VOL_W + 1;
   // Room for CHANNELS worth of products without overflow
   localparam int ACC_W  = WIDTH + VOL_W + SEL_W + 1;

   // Saturation bounds expressed at accumulator width
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                     state;

   // Configuration captured at the tick; mid-frame input changes only
   // influence the following frame.
   logic [CHANNELS-1:0]        en_reg;
   logic [CHANNELS*VOL_W-1:0]  vol_reg;
   logic signed [ACC_W-1:0]    acc_reg;

   // Enable set derived from the live inputs, used only at the tick
   logic [CHANNELS-1:0]        en_in;
   logic [SEL_W-1:0]           first_idx;
   logic                       first_found;

   // Next enabled channel strictly above the current one
   logic [SEL_W-1:0]           next_idx;
   logic                       next_found;

   // Per-channel view of the latched volumes
   logic [VOL_W-1:0]           vol_arr [CHANNELS];
   logic [VOL_W-1:0]           cur_vol;

   logic signed [PROD_W-1:0]   data_ext;
   logic signed [PROD_W-1:0]   vol_ext;
   logic signed [PROD_W-1:0]   prod;
   logic signed [ACC_W-1:0]    acc_sum;
   logic signed [ACC_W-1:0]    acc_shift;
   logic signed [WIDTH-1:0]    sat_value;

   genvar gi;

   // Solo overrides mute. A solo index beyond the channel count matches
   // no channel, so the frame is empty.
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_enable
         assign en_in[gi] = solo_enable_in ? ({27'd0, solo_in} == 32'(gi))
                                           : ~mute_in[gi];
      end
   endgenerate

   // Unpack latched volumes into an array indexed by channel
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_vol
         assign vol_arr[gi] = vol_reg[gi*VOL_W +: VOL_W];
      end
   endgenerate

   // Lowest-index enabled channel from the live config (frame start)
   always_comb begin
      first_idx   = '0;
      first_found = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (en_in[i]) begin
            first_idx   = SEL_W'(i);
            first_found = 1'b1;
         end
      end
   end

   // Lowest enabled channel above the current selection (latched config)
   always_comb begin
      next_idx   = '0;
      next_found = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (en_reg[i] && (i > int'(ch_sel_out))) begin
            next_idx   = SEL_W'(i);
            next_found = 1'b1;
         end
      end
   end

   // Signed sample times unsigned volume, then accumulate
   always_comb begin
      cur_vol  = vol_arr[ch_sel_out];
      data_ext = PROD_W'(ch_data_in);
      vol_ext  = PROD_W'({1'b0, cur_vol});
      prod     = data_ext * vol_ext;
      acc_sum  = acc_reg + ACC_W'(prod);
   end

   // Remove the unity-gain factor of 8 and clamp to the output range
   always_comb begin
      acc_shift = acc_reg >>> 3;
      if (acc_shift > SAT_MAX) begin
         sat_value = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (acc_shift < SAT_MIN) begin
         sat_value = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         sat_value = acc_shift[WIDTH-1:0];
      end
   end

   // Frame FSM with all outputs registered
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state         <= IDLE;
         en_reg        <= '0;
         vol_reg       <= '0;
         acc_reg       <= '0;
         ch_req_out    <= 1'b0;
         ch_sel_out    <= '0;
         mix_out       <= '0;
         mix_valid_out <= 1'b0;
         busy_out      <= 1'b0;
         overrun_out   <= 1'b0;
      end else begin
         mix_valid_out <= 1'b0;
         // A tick anywhere outside IDLE (including DONE) is an overrun
         overrun_out   <= sample_tick_in && (state != IDLE);
         case (state)
            IDLE: begin
               if (sample_tick_in) begin
                  en_reg   <= en_in;
                  vol_reg  <= volume_in;
                  acc_reg  <= '0;
                  busy_out <= 1'b1;
                  if (first_found) begin
                     state      <= FETCH;
                     ch_req_out <= 1'b1;
                     ch_sel_out <= first_idx;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            FETCH: begin
               // ch_req_out is high throughout FETCH, so ack alone qualifies
               if (ch_ack_in) begin
                  acc_reg <= acc_sum;
                  if (next_found) begin
                     ch_sel_out <= next_idx;
                  end else begin
                     state      <= DONE;
                     ch_req_out <= 1'b0;
                  end
               end
            end
            DONE: begin
               mix_out       <= sat_value;
               mix_valid_out <= 1'b1;
               busy_out      <= 1'b0;
               state         <= IDLE;
            end
            default: begin
               state      <= IDLE;
               ch_req_out <= 1'b0;
               busy_out   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mix_scheduler.sv
// tb_mix_scheduler: randomized plus directed frames against a behavioural
// mixing model (enabled list, weighted sum, /8 floor, clamp, latency).

module tb_mix_scheduler;

   localparam int WIDTH    = 16;
   localparam int CHANNELS = 4;
   localparam int VOL_W    = 4;

   logic                        clk_in = 1'b0;
   logic                        rst_n_in = 1'b0;
   logic                        sample_tick_in = 1'b0;
   logic                        ch_req_out;
   logic [1:0]                  ch_sel_out;
   logic                        ch_ack_in = 1'b0;
   logic signed [WIDTH-1:0]     ch_data_in = '0;
   logic [CHANNELS-1:0]         mute_in = '0;
   logic [CHANNELS*VOL_W-1:0]   volume_in = '0;
   logic                        solo_enable_in = 1'b0;
   logic [4:0]                  solo_in = '0;
   logic signed [WIDTH-1:0]     mix_out;
   logic                        mix_valid_out;
   logic                        busy_out;
   logic                        overrun_out;

   int errors = 0;
   int checks = 0;

   int data_mem [CHANNELS];
   int cfg_vol  [CHANNELS];
   int ack_wait = 0;
   int wait_cnt = 0;
   int req_seq = 0;
   int valid_cnt = 0;
   int ovr_cnt = 0;
   int sel_err = 0;
   logic       prev_pending = 1'b0;
   logic [1:0] prev_sel = '0;

   mix_scheduler #(
      .WIDTH(WIDTH), .CHANNELS(CHANNELS), .VOL_W(VOL_W)
   ) dut (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .sample_tick_in(sample_tick_in),
      .ch_req_out(ch_req_out),
      .ch_sel_out(ch_sel_out),
      .ch_ack_in(ch_ack_in),
      .ch_data_in(ch_data_in),
      .mute_in(mute_in),
      .volume_in(volume_in),
      .solo_enable_in(solo_enable_in),
      .solo_in(solo_in),
      .mix_out(mix_out),
      .mix_valid_out(mix_valid_out),
      .busy_out(busy_out),
      .overrun_out(overrun_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Channel source: answers requests after ack_wait idle cycles, records
   // the acknowledged channel order and watches output pulses.
   initial begin
      forever begin
         @(negedge clk_in);
         if (mix_valid_out) valid_cnt++;
         if (overrun_out) ovr_cnt++;
         if (ch_req_out && rst_n_in) begin
            if (prev_pending && (ch_sel_out != prev_sel)) sel_err++;
            if (wait_cnt >= ack_wait) begin
               ch_ack_in    = 1'b1;
               ch_data_in   = 16'(data_mem[ch_sel_out]);
               wait_cnt     = 0;
               req_seq      = req_seq * 10 + int'(ch_sel_out) + 1;
               prev_pending = 1'b0;
            end else begin
               ch_ack_in    = 1'b0;
               ch_data_in   = 16'($urandom);
               wait_cnt++;
               prev_pending = 1'b1;
               prev_sel     = ch_sel_out;
            end
         end else begin
            // ack noise while no request is outstanding must be ignored
            ch_ack_in    = 1'($urandom_range(0, 1));
            ch_data_in   = 16'($urandom);
            wait_cnt     = 0;
            prev_pending = 1'b0;
         end
      end
   end

   task automatic run_frame(input string tag, input logic [3:0] mute,
                            input logic solo_en, input int solo,
                            input int wait_c, input int ovr_at,
                            input logic scramble);
      int     exp_seq = 0;
      int     n = 0;
      longint sum = 0;
      longint expv;
      int     lat;
      int     got_lat = -1;
      int     exp_ovr;
      bit     en;
      logic signed [WIDTH-1:0] held;

      for (int i = 0; i < CHANNELS; i++) begin
         en = solo_en ? (solo == i) : !mute[i];
         if (en) begin
            n++;
            exp_seq = exp_seq * 10 + i + 1;
            sum += longint'(data_mem[i]) * cfg_vol[i];
         end
      end
      expv = sum >>> 3;
      if (expv > 32767) expv = 32767;
      if (expv < -32768) expv = -32768;
      lat = n + 1 + n * wait_c;
      exp_ovr = (ovr_at >= 1 && ovr_at <= lat) ? 1 : 0;

      @(negedge clk_in);
      mute_in        = mute;
      for (int i = 0; i < CHANNELS; i++) volume_in[i*VOL_W +: VOL_W] = 4'(cfg_vol[i]);
      solo_enable_in = solo_en;
      solo_in        = 5'(solo);
      ack_wait       = wait_c;
      req_seq        = 0;
      valid_cnt      = 0;
      ovr_cnt        = 0;
      sel_err        = 0;
      sample_tick_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      sample_tick_in = 1'b0;
      if (scramble) begin
         mute_in        = 4'($urandom);
         volume_in      = 16'($urandom);
         solo_enable_in = 1'($urandom);
         solo_in        = 5'($urandom);
      end
      for (int e = 1; e <= 200 && got_lat < 0; e++) begin
         if (e == ovr_at) sample_tick_in = 1'b1;
         @(posedge clk_in);
         @(negedge clk_in);
         sample_tick_in = 1'b0;
         if (mix_valid_out) got_lat = e;
      end
      check({tag, " latency"}, got_lat, lat);
      check({tag, " mix_out"}, mix_out, expv);
      check({tag, " req_order"}, req_seq, exp_seq);
      held = mix_out;
      repeat (3) @(negedge clk_in);
      check({tag, " valid_pulses"}, valid_cnt, 1);
      check({tag, " overruns"}, ovr_cnt, exp_ovr);
      check({tag, " sel_stable"}, sel_err, 0);
      check({tag, " busy_idle"}, busy_out, 0);
      check({tag, " mix_hold"}, mix_out, held);
      $display("frame %s: n=%0d wait=%0d mix=%0d latency=%0d", tag, n, wait_c, mix_out, got_lat);
   endtask

   task automatic set_basic();
      data_mem[0] = 1000; data_mem[1] = 2000; data_mem[2] = -500; data_mem[3] = 300;
      for (int i = 0; i < CHANNELS; i++) cfg_vol[i] = 8;
   endtask

   initial begin
      logic signed [WIDTH-1:0] tmp;

      // Reset state
      repeat (3) @(negedge clk_in);
      check("rst req", ch_req_out, 0);
      check("rst sel", ch_sel_out, 0);
      check("rst mix", mix_out, 0);
      check("rst valid", mix_valid_out, 0);
      check("rst busy", busy_out, 0);
      check("rst overrun", overrun_out, 0);
      rst_n_in = 1'b1;
      repeat (2) @(negedge clk_in);

      // Directed frames
      set_basic();
      run_frame("basic", 4'b0000, 1'b0, 0, 0, 0, 1'b0);
      for (int i = 0; i < CHANNELS; i++) begin data_mem[i] = 30000; cfg_vol[i] = 15; end
      run_frame("sat_pos", 4'b0000, 1'b0, 0, 0, 0, 1'b0);
      for (int i = 0; i < CHANNELS; i++) data_mem[i] = -30000;
      run_frame("sat_neg", 4'b0000, 1'b0, 0, 0, 0, 1'b0);
      set_basic();
      run_frame("mute1010", 4'b1010, 1'b0, 0, 0, 0, 1'b0);
      run_frame("solo2", 4'b0100, 1'b1, 2, 0, 0, 1'b0);
      run_frame("solo7", 4'b0000, 1'b1, 7, 0, 0, 1'b0);
      run_frame("wait3", 4'b0000, 1'b0, 0, 3, 0, 1'b0);
      run_frame("overrun", 4'b0000, 1'b0, 0, 0, 2, 1'b0);
      run_frame("done_tick", 4'b0000, 1'b1, 7, 0, 1, 1'b0);

      // Reset during the second fetch aborts the frame
      @(negedge clk_in);
      mute_in = '0; solo_enable_in = 1'b0; ack_wait = 0;
      for (int i = 0; i < CHANNELS; i++) volume_in[i*VOL_W +: VOL_W] = 4'd8;
      sample_tick_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      sample_tick_in = 1'b0;
      @(posedge clk_in);
      @(negedge clk_in);
      check("midrst sel_before", ch_sel_out, 1);
      valid_cnt = 0;
      rst_n_in = 1'b0;
      #1;
      check("midrst req", ch_req_out, 0);
      check("midrst sel", ch_sel_out, 0);
      check("midrst mix", mix_out, 0);
      check("midrst valid", mix_valid_out, 0);
      check("midrst busy", busy_out, 0);
      check("midrst overrun", overrun_out, 0);
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      repeat (8) @(negedge clk_in);
      check("midrst no_valid", valid_cnt, 0);
      run_frame("after_rst", 4'b0000, 1'b0, 0, 0, 0, 1'b0);

      // Randomized frames, including mid-frame config changes
      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < CHANNELS; i++) begin
            tmp = 16'($urandom);
            data_mem[i] = int'(tmp);
            cfg_vol[i]  = $urandom_range(0, 15);
         end
         run_frame($sformatf("rand%0d", f), 4'($urandom),
                   ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
                   $urandom_range(0, 3),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                   1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
